// File: rtl/mem_pkg.sv
// Shared helpers and clear-FSM state encoding for the mem_mr emulated memory.
package mem_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  function automatic int addr_w(input int depth);
    int w;
    w = 0;
    while ((1 << w) < depth) w++;
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int nstrb(input int width, input int gran);
    return (width + gran - 1) / gran;
  endfunction

endpackage

// File: rtl/mem_rd_port.sv
// One read port: range check, same-cycle write merge and optional output register.
module mem_rd_port #(
  parameter int WIDTH    = 80,
  parameter int DEPTH    = 64,
  parameter int AW       = 6,
  parameter int SYNCREAD = 0,
  parameter int BYPASS   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_ren,
  input  logic [AW-1:0]    i_raddr,
  input  logic [WIDTH-1:0] i_word,
  input  logic             i_busy,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [WIDTH-1:0] i_wr_mask,
  output logic [WIDTH-1:0] o_rdata
);

  logic             w_in_range;
  logic             w_hit;
  logic [WIDTH-1:0] w_merged;
  logic [WIDTH-1:0] w_value;
  logic             w_unused_ok;

  // A fully populated address space needs no comparison at all.
  if (DEPTH >= (1 << AW)) begin : g_full
    assign w_in_range = 1'b1;
  end else begin : g_part
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
    assign w_in_range = ({1'b0, i_raddr} < DEPTH_W);
  end

  assign w_hit    = (SYNCREAD != 0) && (BYPASS != 0) && i_wr_en && (i_wr_addr == i_raddr);
  assign w_merged = w_hit ? ((i_word & ~i_wr_mask) | (i_wr_data & i_wr_mask)) : i_word;
  assign w_value  = (i_busy || !w_in_range) ? '0 : w_merged;

  if (SYNCREAD != 0) begin : g_sync
    logic [WIDTH-1:0] r_rdata;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_rdata <= '0;
      end else if (i_ren) begin
        r_rdata <= w_value;
      end
    end
    assign o_rdata = r_rdata;
  end else begin : g_async
    assign o_rdata = w_value;
  end

  assign w_unused_ok = ^{clk, rst, i_ren, i_wr_data, i_wr_mask};

endmodule

// File: rtl/mem_mr.sv
// Multi-read-port emulated memory with strobed writes and a post-reset clear sequencer.
module mem_mr
  import mem_pkg::*;
#(
  parameter int WIDTH        = 80,
  parameter int DEPTH        = 64,
  parameter int NREAD        = 2,
  parameter int SYNCREAD     = 0,
  parameter int GRAN         = 8,
  parameter int BYPASS       = 1,
  parameter int CLEAR_ON_RST = 1,
  localparam int AW          = addr_w(DEPTH),
  localparam int NSTRB       = nstrb(WIDTH, GRAN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREAD-1:0]       ren,
  input  logic [NREAD*AW-1:0]    raddr,
  output logic [NREAD*WIDTH-1:0] rdata,
  input  logic                   wen,
  input  logic [AW-1:0]          waddr,
  input  logic [WIDTH-1:0]       wdata,
  input  logic [NSTRB-1:0]       wstrb,
  output logic                   busy
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  clr_state_e       r_state;
  clr_state_e       w_state_nxt;
  logic [AW-1:0]    r_clr_cnt;
  logic [AW-1:0]    w_clr_cnt_nxt;
  logic             w_waddr_ok;
  logic             w_wr_ok;
  logic [WIDTH-1:0] w_wmask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    if (r_state == ST_CLEAR) begin
      w_clr_cnt_nxt = r_clr_cnt + 1'b1;
      if (r_clr_cnt == AW'(DEPTH - 1)) begin
        w_state_nxt   = ST_IDLE;
        w_clr_cnt_nxt = '0;
      end
    end
  end

  assign busy = (r_state == ST_CLEAR);

  if (DEPTH >= (1 << AW)) begin : g_wfull
    assign w_waddr_ok = 1'b1;
  end else begin : g_wpart
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
    assign w_waddr_ok = ({1'b0, waddr} < DEPTH_W);
  end

  assign w_wr_ok = wen && !busy && w_waddr_ok;

  // Expand lane strobes to a per-bit mask; the last lane may be narrower than GRAN.
  for (genvar b = 0; b < WIDTH; b++) begin : g_mask
    assign w_wmask[b] = wstrb[b / GRAN];
  end

  // Clearing takes priority; user writes are already blocked while busy.
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_clr_cnt] <= '0;
    end else if (w_wr_ok) begin
      r_mem[waddr] <= (r_mem[waddr] & ~w_wmask) | (wdata & w_wmask);
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0]    w_raddr;
    logic [WIDTH-1:0] w_word;
    assign w_raddr = raddr[i*AW +: AW];
    assign w_word  = r_mem[w_raddr];

    mem_rd_port #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .AW      (AW),
      .SYNCREAD(SYNCREAD),
      .BYPASS  (BYPASS)
    ) u_rd (
      .clk      (clk),
      .rst      (rst),
      .i_ren    (ren[i]),
      .i_raddr  (w_raddr),
      .i_word   (w_word),
      .i_busy   (busy),
      .i_wr_en  (w_wr_ok),
      .i_wr_addr(waddr),
      .i_wr_data(wdata),
      .i_wr_mask(w_wmask),
      .o_rdata  (rdata[i*WIDTH +: WIDTH])
    );
  end

endmodule
